// File: rtl/ipa_pkg.sv
// Shared constants, processing-mode enum and pointer-width helper for the IPA slave path.
package ipa_pkg;

  localparam int MODE_W = 2;
  localparam int PROC_W = 8;

  typedef enum logic [MODE_W-1:0] {
    MODE_RAW    = 2'd0,
    MODE_SCALE  = 2'd1,
    MODE_ACCUM  = 2'd2,
    MODE_BYPASS = 2'd3
  } ipa_mode_e;

  // One extra MSB beyond the index lets equal indices mean either empty or full.
  function automatic int ipa_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ipa_fifo_mem.sv
// 1W1R register array with synchronous write and a registered, write-first read port.
module ipa_fifo_mem #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Write-first bypass lets a beat written into an empty queue appear as head next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/ipa_slv_fifo.sv
// Arbiter-to-master beat FIFO with FWFT registered outputs and early fifo_full warning.
// Optional IPA_FIFO_ERR_STATUS_EN adds sticky ovf_err and saturating drop_cnt outputs.
module ipa_slv_fifo
  import ipa_pkg::*;
#(
  parameter int DW        = 32,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_valid,
  input  logic [MODE_W-1:0]      wr_mode,
  input  logic [PROC_W-1:0]      wr_proc_val,
  input  logic [DW-1:0]          wr_data,
  output logic                   fifo_full,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [MODE_W-1:0]      rd_mode,
  output logic [PROC_W-1:0]      rd_proc_val,
  output logic [DW-1:0]          rd_data,
  output logic [$clog2(DEPTH):0] count
`ifdef IPA_FIFO_ERR_STATUS_EN
  ,
  output logic                   ovf_err,
  output logic [7:0]             drop_cnt
`endif
);

  localparam int PW = ipa_ptr_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DW + MODE_W + PROC_W;
  localparam logic [PW-1:0] ONE     = PW'(1);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LVL  = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, count_nxt;
  logic          wr_en, rd_en;
  logic [EW-1:0] rd_entry;
  ipa_mode_e     head_mode;

  // A read never frees space for a write in the same cycle.
  assign wr_en = wr_valid && (count < DEPTH_C) && !flush;
  assign rd_en = rd_valid && rd_ready && !flush;

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (rd_en) rd_ptr_nxt = rd_ptr + ONE;
      case ({wr_en, rd_en})
        2'b10:   count_nxt = count + ONE;
        2'b01:   count_nxt = count - ONE;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      fifo_full <= 1'b0;
    end else begin
      wr_ptr    <= flush ? '0 : (wr_en ? wr_ptr + ONE : wr_ptr);
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      rd_valid  <= (count_nxt != '0);
      fifo_full <= (count_nxt >= AF_LVL);
    end
  end

  // Read address tracks the next head so the registered read port is the output stage.
  ipa_fifo_mem #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_en),
    .waddr(wr_ptr[AW-1:0]),
    .wdata({wr_mode, wr_proc_val, wr_data}),
    .raddr(rd_ptr_nxt[AW-1:0]),
    .rdata(rd_entry)
  );

  assign head_mode   = ipa_mode_e'(rd_entry[EW-1 -: MODE_W]);
  assign rd_mode     = head_mode;
  assign rd_proc_val = rd_entry[DW +: PROC_W];
  assign rd_data     = rd_entry[DW-1:0];

`ifdef IPA_FIFO_ERR_STATUS_EN
  logic drop;

  assign drop = wr_valid && !flush && (count == DEPTH_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err  <= 1'b0;
      drop_cnt <= '0;
    end else if (flush) begin
      ovf_err  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf_err  <= 1'b1;
      drop_cnt <= (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ipa_slv_fifo.sv
// Self-checking bench for ipa_slv_fifo: directed scenarios plus a randomized run against a queue model.
module tb_ipa_slv_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;
  localparam int THR   = DEPTH - AFM;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_mode = '0;
  logic [7:0]  wr_proc_val = '0;
  logic [31:0] wr_data = '0;
  logic        rd_ready = 1'b0;
  logic        fifo_full, rd_valid;
  logic [1:0]  rd_mode;
  logic [7:0]  rd_proc_val;
  logic [31:0] rd_data;
  logic [4:0]  count;
`ifdef IPA_FIFO_ERR_STATUS_EN
  logic        ovf_err;
  logic [7:0]  drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of {mode, proc_val, data} plus drop bookkeeping.
  logic [41:0] mq[$];
  int          m_drop = 0;
  bit          m_ovf = 1'b0;

  always #5 clk = ~clk;

  ipa_slv_fifo #(.DW(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_mode(wr_mode), .wr_proc_val(wr_proc_val), .wr_data(wr_data),
    .fifo_full(fifo_full), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_mode(rd_mode), .rd_proc_val(rd_proc_val), .rd_data(rd_data), .count(count)
`ifdef IPA_FIFO_ERR_STATUS_EN
    , .ovf_err(ovf_err), .drop_cnt(drop_cnt)
`endif
  );

  task automatic set_in(input bit wv, input logic [1:0] m, input logic [7:0] pv,
                        input logic [31:0] d, input bit rr, input bit fl);
    wr_valid = wv; wr_mode = m; wr_proc_val = pv; wr_data = d; rd_ready = rr; flush = fl;
  endtask

  // Advance one clock and update the model from the inputs presented before the edge.
  task automatic step();
    bit wa, ra, dr;
    wa = wr_valid && (mq.size() < DEPTH) && !flush;
    ra = (mq.size() != 0) && rd_ready && !flush;
    dr = wr_valid && !flush && (mq.size() == DEPTH);
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete(); m_drop = 0; m_ovf = 1'b0;
    end else begin
      if (ra) void'(mq.pop_front());
      if (wa) mq.push_back({wr_mode, wr_proc_val, wr_data});
      if (dr) begin m_ovf = 1'b1; if (m_drop < 255) m_drop++; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    n_tests++; if (fifo_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fifo_full got=%b exp=0", fifo_full); end
    n_tests++; if ({rd_mode, rd_proc_val, rd_data} !== 42'd0) begin n_fail++; $display("[TB] FAIL reset_rd_fields got=%h exp=0", {rd_mode, rd_proc_val, rd_data}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    set_in(1'b1, 2'd2, 8'hA5, 32'hDEADBEEF, 1'b1, 1'b0);
    step();
    wr_valid = 1'b0;
    n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_rd_valid got=%b exp=1", rd_valid); end
    n_tests++; if ({rd_mode, rd_proc_val, rd_data} !== {2'd2, 8'hA5, 32'hDEADBEEF}) begin n_fail++; $display("[TB] FAIL single_fields got=%h exp=%h", {rd_mode, rd_proc_val, rd_data}, {2'd2, 8'hA5, 32'hDEADBEEF}); end
    n_tests++; if (count !== 5'd1) begin n_fail++; $display("[TB] FAIL single_count got=%0d exp=1", count); end
    step();
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_drained_valid got=%b exp=0", rd_valid); end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL single_drained_count got=%0d exp=0", count); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 2'(i), 8'(i * 3), 32'(i), 1'b0, 1'b0);
      step();
      n_tests++; if (count !== 5'(i + 1)) begin n_fail++; $display("[TB] FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
      n_tests++; if (fifo_full !== ((i + 1) >= THR)) begin n_fail++; $display("[TB] FAIL fill_full[%0d] got=%b exp=%b", i, fifo_full, (i + 1) >= THR); end
    end
    set_in(1'b1, 2'd3, 8'hFF, 32'h0000_0099, 1'b0, 1'b0);
    step();
    n_tests++; if (count !== 5'd16) begin n_fail++; $display("[TB] FAIL ovf_count got=%0d exp=16", count); end
    n_tests++; if (rd_data !== 32'd0) begin n_fail++; $display("[TB] FAIL ovf_head got=%h exp=0", rd_data); end
`ifdef IPA_FIFO_ERR_STATUS_EN
    n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL ovf_drop_cnt got=%0d exp=1", drop_cnt); end
    n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_err got=%b exp=1", ovf_err); end
`endif
    // Read plus write while full: the write is still dropped.
    set_in(1'b1, 2'd3, 8'hEE, 32'h0000_0098, 1'b1, 1'b0);
    step();
    n_tests++; if (count !== 5'd15) begin n_fail++; $display("[TB] FAIL full_rw_count got=%0d exp=15", count); end
    n_tests++; if (rd_data !== 32'd1) begin n_fail++; $display("[TB] FAIL full_rw_head got=%h exp=1", rd_data); end
    n_tests++; if (fifo_full !== 1'b1) begin n_fail++; $display("[TB] FAIL full_rw_flag got=%b exp=1", fifo_full); end
`ifdef IPA_FIFO_ERR_STATUS_EN
    n_tests++; if (drop_cnt !== 8'd2) begin n_fail++; $display("[TB] FAIL full_rw_drop_cnt got=%0d exp=2", drop_cnt); end
`endif
    set_in(1'b0, 2'd0, 8'h0, 32'h0, 1'b0, 1'b1);
    step();
    flush = 1'b0;
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL full_flush_count got=%0d exp=0", count); end
    n_tests++; if (fifo_full !== 1'b0) begin n_fail++; $display("[TB] FAIL full_flush_flag got=%b exp=0", fifo_full); end
`ifdef IPA_FIFO_ERR_STATUS_EN
    n_tests++; if ({ovf_err, drop_cnt} !== 9'd0) begin n_fail++; $display("[TB] FAIL full_flush_err got=%h exp=0", {ovf_err, drop_cnt}); end
`endif
  endtask

  task automatic test_wrap_drain();
    int wr_next = 16;
    int rd_exp  = 0;
    bit wacc;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 2'd1, 8'h5A, 32'(i), 1'b0, 1'b0);
      step();
    end
    for (int cyc = 0; cyc < 100 && rd_exp < 24; cyc++) begin
      set_in(wr_next < 24, 2'd1, 8'h5A, 32'(wr_next), 1'b1, 1'b0);
      if (mq.size() != 0) begin
        n_tests++; if (rd_data !== 32'(rd_exp)) begin n_fail++; $display("[TB] FAIL wrap_order got=%0d exp=%0d", rd_data, rd_exp); end
        rd_exp++;
      end
      wacc = wr_valid && (mq.size() < DEPTH);
      step();
      if (wacc) wr_next++;
      n_tests++; if (fifo_full !== (mq.size() >= THR)) begin n_fail++; $display("[TB] FAIL wrap_full got=%b exp=%b", fifo_full, mq.size() >= THR); end
    end
    n_tests++; if (rd_exp !== 24) begin n_fail++; $display("[TB] FAIL wrap_total got=%0d exp=24", rd_exp); end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL wrap_end_count got=%0d exp=0", count); end
    set_in(1'b0, 2'd0, 8'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_in(1'b1, 2'd0, 8'h11, 32'd100, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, 2'd0, 8'h11, 32'(101 + k), 1'b1, 1'b0);
      n_tests++; if (rd_data !== 32'(100 + k)) begin n_fail++; $display("[TB] FAIL b2b_data got=%0d exp=%0d", rd_data, 100 + k); end
      step();
      n_tests++; if (count !== 5'd1) begin n_fail++; $display("[TB] FAIL b2b_count got=%0d exp=1", count); end
      n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_valid got=%b exp=1", rd_valid); end
    end
    n_tests++; if (rd_data !== 32'd110) begin n_fail++; $display("[TB] FAIL b2b_last got=%0d exp=110", rd_data); end
    set_in(1'b0, 2'd0, 8'h0, 32'h0, 1'b1, 1'b0);
    step();
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL b2b_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, 2'd2, 8'h22, 32'(200 + i), 1'b0, 1'b0);
      step();
    end
    n_tests++; if (count !== 5'd9) begin n_fail++; $display("[TB] FAIL flush_pre_count got=%0d exp=9", count); end
    set_in(1'b1, 2'd2, 8'h22, 32'hBAD0BAD0, 1'b1, 1'b1);
    step();
    set_in(1'b0, 2'd0, 8'h0, 32'h0, 1'b0, 1'b0);
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL flush_count got=%0d exp=0", count); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid got=%b exp=0", rd_valid); end
    n_tests++; if (fifo_full !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_full got=%b exp=0", fifo_full); end
    set_in(1'b1, 2'd1, 8'h33, 32'h0000600D, 1'b0, 1'b0);
    step();
    set_in(1'b0, 2'd0, 8'h0, 32'h0, 1'b1, 1'b0);
    n_tests++; if (rd_data !== 32'h0000600D) begin n_fail++; $display("[TB] FAIL flush_next_head got=%h exp=0000600d", rd_data); end
    step();
    rd_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 2'd3, 8'h44, 32'(300 + i), 1'b0, 1'b0);
      step();
    end
    wr_valid = 1'b0;
    n_tests++; if (count !== 5'd5) begin n_fail++; $display("[TB] FAIL areset_pre_count got=%0d exp=5", count); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({rd_valid, count, fifo_full} !== 7'd0) begin n_fail++; $display("[TB] FAIL areset_flags got=%h exp=0", {rd_valid, count, fifo_full}); end
    n_tests++; if ({rd_mode, rd_proc_val, rd_data} !== 42'd0) begin n_fail++; $display("[TB] FAIL areset_fields got=%h exp=0", {rd_mode, rd_proc_val, rd_data}); end
    mq.delete(); m_drop = 0; m_ovf = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    set_in(1'b1, 2'd1, 8'h77, 32'h11111111, 1'b0, 1'b0);
    step();
    wr_valid = 1'b0;
    n_tests++; if ({rd_valid, rd_data} !== {1'b1, 32'h11111111}) begin n_fail++; $display("[TB] FAIL areset_first_beat got=%h exp=%h", {rd_valid, rd_data}, {1'b1, 32'h11111111}); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      set_in($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom), $urandom,
             ((cyc / 80) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
             $urandom_range(0, 63) == 0);
      step();
      n_tests++; if (count !== 5'(mq.size())) begin n_fail++; $display("[TB] FAIL rand_count got=%0d exp=%0d", count, mq.size()); end
      n_tests++; if (rd_valid !== (mq.size() != 0)) begin n_fail++; $display("[TB] FAIL rand_valid got=%b exp=%b", rd_valid, mq.size() != 0); end
      n_tests++; if (fifo_full !== (mq.size() >= THR)) begin n_fail++; $display("[TB] FAIL rand_full got=%b exp=%b", fifo_full, mq.size() >= THR); end
      if (mq.size() != 0) begin
        n_tests++; if ({rd_mode, rd_proc_val, rd_data} !== mq[0]) begin n_fail++; $display("[TB] FAIL rand_head got=%h exp=%h", {rd_mode, rd_proc_val, rd_data}, mq[0]); end
      end
`ifdef IPA_FIFO_ERR_STATUS_EN
      n_tests++; if ({ovf_err, drop_cnt} !== {m_ovf, 8'(m_drop)}) begin n_fail++; $display("[TB] FAIL rand_err got=%h exp=%h", {ovf_err, drop_cnt}, {m_ovf, 8'(m_drop)}); end
`endif
    end
    set_in(1'b0, 2'd0, 8'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_wrap_drain();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
